// File: rtl/nios2_button_ctrl.sv
// -----------------------------------------------------------------------------
// nios2_button_ctrl
//
// Avalon-MM push-button peripheral for a Nios II system. Raw active-low button
// inputs are synchronized and optionally debounced. A press is a 1->0 change of
// the debounced level. Each press sets a sticky edge_capture bit, and a level
// interrupt is raised for every captured bit that is enabled in irq_mask.
//
// Build option:
//   BUTTON_CTRL_DEBOUNCE_EN  defined   -> per-bit STABLE/COUNTING debounce FSMs
//                                          with saturating counters.
//                            undefined -> debounced state is the synchronizer
//                                          output (2 cycles after in_port), and
//                                          no counters are built.
//
// Ports:
//   clk        in   single rising-edge clock
//   reset      in   synchronous, active-high reset
//   address    in   [1:0]  word address (0 state, 1 irq_mask, 2 edge_capture, 3 rsvd)
//   read       in   read strobe; readdata updates on the following edge
//   write      in   write strobe
//   writedata  in   [31:0] write data; bits above WIDTH-1 are ignored
//   readdata   out  [31:0] registered read data; bits above WIDTH-1 read 0
//   in_port    in   [WIDTH-1:0] raw asynchronous buttons, 0 = pressed
//   irq        out  |(edge_capture & irq_mask)
// -----------------------------------------------------------------------------
module nios2_button_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGE  = 2'd2;

  // Synchronizer, register file and read port.
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [31:0]      readdata_q, readdata_d;

  // Current debounced level and the value it takes on the next edge. The
  // press detector compares the two so edge_capture sets on the same edge the
  // debounced bit falls.
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] clear;

`ifdef BUTTON_CTRL_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0]            fsm_q, fsm_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            deb_q, deb_d;

  // The counter tallies consecutive cycles on which the synced level differs
  // from the debounced level. The cycle that triggers STABLE->COUNTING is the
  // first such cycle, so the count enters COUNTING at 1. The new level is then
  // accepted after exactly DEBOUNCE_CYCLES differing cycles, and the counter
  // never passes CNT_LAST.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      case (fsm_q[i])
        ST_STABLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i] != deb_q[i]) begin
            if (DEBOUNCE_CYCLES <= 1) begin
              deb_d[i] = sync2_q[i];
            end else begin
              fsm_d[i] = ST_COUNTING;
              cnt_d[i] = CNT_ONE;
            end
          end
        end
        default: begin
          if (sync2_q[i] == deb_q[i]) begin
            // Glitch: the level went back before it was qualified.
            fsm_d[i] = ST_STABLE;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = sync2_q[i];
            fsm_d[i] = ST_STABLE;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-bit counters and FSM states are a small register array,
      // not a RAM, so they are all reset. A reset mid-count abandons the count.
      fsm_q <= {WIDTH{ST_STABLE}};
      cnt_q <= '0;
      deb_q <= '1;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign state      = deb_q;
  assign state_next = deb_d;
`else
  // The debounce length is not used when the filter is compiled out.
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign state      = sync2_q;
  assign state_next = sync1_q;
`endif

  assign press = state & ~state_next;
  assign clear = (write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;

    irq_mask_d = irq_mask_q;
    if (write && (address == ADDR_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end

    // A press on the same cycle as a write-1-clear must survive, so the set
    // term is ORed in after the clear.
    edge_capture_d = (edge_capture_q & ~clear) | press;

    // The read port samples the current registers, so a read that coincides
    // with a write to the same address returns the pre-write value.
    readdata_d = readdata_q;
    if (read) begin
      readdata_d = '0;
      case (address)
        ADDR_STATE: readdata_d[WIDTH-1:0] = state;
        ADDR_MASK:  readdata_d[WIDTH-1:0] = irq_mask_q;
        ADDR_EDGE:  readdata_d[WIDTH-1:0] = edge_capture_q;
        default:    readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronizer comes out of reset at the released level, so leaving
      // reset never looks like a press.
      sync1_q        <= '1;
      sync2_q        <= '1;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so that
      // every flop samples the pre-edge values of the others.
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

  // Upper write-data bits carry no register state.
  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:WIDTH];
  end

endmodule

// File: doc/nios2_button_ctrl.md
NIOS2_BUTTON_CTRL -- requirements
Module: nios2_button_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: number of push-button inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a new level (1 ms at 50 MHz).
REQ-003 clk  input  1: single clock; all logic is rising-edge clk.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 address  input  2: Avalon-MM slave word address.
REQ-006 read  input  1: Avalon-MM read strobe.
REQ-007 write  input  1: Avalon-MM write strobe.
REQ-008 writedata  input  32: Avalon-MM write data; bits above WIDTH-1 are ignored.
REQ-009 readdata  output  32: registered read data; bits above WIDTH-1 read 0.
REQ-010 in_port  input  WIDTH: raw asynchronous buttons, active-low (0 = pressed).
REQ-011 irq  output  1: level interrupt to the processor.

Function
REQ-012 Each in_port bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each bit SHALL have an independent debounce FSM with states STABLE and COUNTING.
REQ-014 STABLE: synced level equals the debounced level; counter held at 0; synced level differing moves the FSM to COUNTING.
REQ-015 COUNTING: counter increments each cycle while synced level differs; synced level matching the debounced level returns the FSM to STABLE with counter 0 (glitch rejected).
REQ-016 COUNTING: when the counter reaches DEBOUNCE_CYCLES-1, the debounced bit SHALL take the synced level on the next edge and the FSM SHALL return to STABLE; the counter never wraps.
REQ-017 The counter width SHALL be clog2(DEBOUNCE_CYCLES), with a minimum of 1.
REQ-018 A 1-to-0 transition of a debounced bit (press) SHALL set the matching edge_capture bit in the same cycle the debounced bit changes.
REQ-019 Address map:
- 0: debounced state, read-only.
- 1: irq_mask, read/write.
- 2: edge_capture, where a written 1 clears the bit.
- 3: reserved, reads 0, writes ignored.
REQ-020 Read latency SHALL be 1 cycle: readdata updates on the edge after read=1 and holds otherwise.
REQ-021 When a set event and a write-1-clear hit the same edge_capture bit in the same cycle, the set SHALL win.
REQ-022 irq SHALL equal |(edge_capture & irq_mask), taken directly from registered state with no added delay.
REQ-023 A write to address 1 or 2 SHALL take effect on the next clock edge; a simultaneous read of the same address returns the pre-write value.

Reset
REQ-024 On reset = 1 at a clock edge, the block SHALL enter this state:
- readdata = 0.
- irq_mask = 0.
- edge_capture = 0.
- irq = 0.
- all counters = 0.
- all FSMs = STABLE.
REQ-025 Reset SHALL set the debounced state and the synchronizer flops to all-ones (released), so that no press edge is generated on exit from reset.
REQ-026 Reset asserted mid-count SHALL abort the count; no debounced change or edge results.

Configuration
REQ-027 With macro BUTTON_CTRL_DEBOUNCE_EN defined, the debounce FSMs and counters of REQ-013..REQ-017 SHALL be compiled in.
REQ-028 Without BUTTON_CTRL_DEBOUNCE_EN, the debounced state SHALL equal the synchronizer output directly, delayed 2 cycles from in_port, with no counters present; REQ-018..REQ-026 still apply.

Verification (bench uses DEBOUNCE_CYCLES=4, WIDTH=4, macro defined unless noted)
REQ-029 Press filtering: in_port=4'hF, then bit0 low for 3 cycles, then high -> no state change, edge_capture=0, irq=0.
REQ-030 Clean press: bit1 held low for 10 cycles -> state at address 0 becomes 4'hD, 2+4 cycles after the drop; edge_capture=4'h2.
REQ-031 Interrupt and clear: irq_mask=4'h2 with bit1 pressed -> irq=1; write 4'h2 to address 2 -> irq=0 next cycle, edge_capture=0.
REQ-032 Set/clear collision: bit2 debounced press on the same cycle as write 4'h4 to address 2 -> edge_capture bit2 stays 1.
REQ-033 Reset mid-count: bit3 low for 2 cycles, then reset pulse, bit3 held low -> state is 4'hF after reset, then 4'h7 only after 2+4 further cycles.
REQ-034 Macro undefined: bit0 low for 1 cycle -> state 4'hE two cycles later, edge_capture=4'h1.
